// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// instruction classes and datapath select codes.
package cu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_MUL2  = 4'b0100;
  localparam logic [3:0] OP_DIV2  = 4'b0101;
  localparam logic [3:0] OP_MOV   = 4'b0110;
  localparam logic [3:0] OP_CLR   = 4'b0111;
  localparam logic [3:0] OP_RST   = 4'b1000;
  localparam logic [3:0] OP_OUT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_BRZ   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] G_ADD  = 4'b0000;
  localparam logic [3:0] G_SUB  = 4'b0001;
  localparam logic [3:0] G_ADDI = 4'b0010;
  localparam logic [3:0] G_SUBI = 4'b0011;
  localparam logic [3:0] G_MUL2 = 4'b0100;
  localparam logic [3:0] G_DIV2 = 4'b0101;
  localparam logic [3:0] G_PASS = 4'b0110;
  localparam logic [3:0] G_CLR  = 4'b0111;

  localparam logic [1:0] MB_REG = 2'b00;
  localparam logic [1:0] MB_IMM = 2'b01;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM_WAIT,
    HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU,
    CL_RST,
    CL_OUT,
    CL_JMP,
    CL_BRZ,
    CL_LOAD,
    CL_STORE,
    CL_HALT
  } iclass_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational map from the instruction register to the datapath control bundle.
// With CU_BRANCH_EN defined, opcode 1101 decodes as BRZ; otherwise it is a NOP.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int REG_COUNT  = 8,
  parameter int DATA_W     = 8,
  parameter int OPCODE_W   = 4,
  localparam int REG_SEL_W = $clog2(REG_COUNT),
  localparam int INSTR_W   = OPCODE_W + 2*REG_SEL_W
) (
  input  logic [INSTR_W-1:0]   ir,
  output logic [REG_SEL_W-1:0] field_a,
  output logic [REG_SEL_W-1:0] field_b,
  output logic [REG_COUNT-1:0] we_onehot,
  output logic [3:0]           g_select,
  output logic [1:0]           mb_select,
  output logic                 mf_select,
  output logic                 md_select,
  output logic [DATA_W-1:0]    constant_in,
  output iclass_e              iclass
);

  logic [OPCODE_W-1:0] opcode;

  assign opcode      = ir[INSTR_W-1 -: OPCODE_W];
  assign field_a     = ir[2*REG_SEL_W-1 -: REG_SEL_W];
  assign field_b     = ir[REG_SEL_W-1:0];
  assign constant_in = DATA_W'(field_b);

  // fieldA values beyond REG_COUNT match no bit, leaving the strobe all-zero
  always_comb begin
    we_onehot = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (field_a == REG_SEL_W'(i)) we_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    iclass    = CL_NOP;
    g_select  = G_ADD;
    mb_select = MB_REG;
    mf_select = 1'b0;
    md_select = 1'b0;
    case (opcode)
      OPCODE_W'(OP_ADD):   begin iclass = CL_ALU; g_select = G_ADD;  md_select = 1'b1; end
      OPCODE_W'(OP_SUB):   begin iclass = CL_ALU; g_select = G_SUB;  md_select = 1'b1; end
      OPCODE_W'(OP_ADDI):  begin iclass = CL_ALU; g_select = G_ADDI; md_select = 1'b1; mb_select = MB_IMM; end
      OPCODE_W'(OP_SUBI):  begin iclass = CL_ALU; g_select = G_SUBI; md_select = 1'b1; mb_select = MB_IMM; end
      OPCODE_W'(OP_MUL2):  begin iclass = CL_ALU; g_select = G_MUL2; md_select = 1'b1; mf_select = 1'b1; end
      OPCODE_W'(OP_DIV2):  begin iclass = CL_ALU; g_select = G_DIV2; md_select = 1'b1; mf_select = 1'b1; end
      OPCODE_W'(OP_MOV):   begin iclass = CL_ALU; g_select = G_PASS; md_select = 1'b1; end
      OPCODE_W'(OP_CLR):   begin iclass = CL_ALU; g_select = G_CLR;  md_select = 1'b1; end
      OPCODE_W'(OP_RST):   iclass = CL_RST;
      OPCODE_W'(OP_OUT):   iclass = CL_OUT;
      OPCODE_W'(OP_JMP):   iclass = CL_JMP;
      OPCODE_W'(OP_LOAD):  iclass = CL_LOAD;
      OPCODE_W'(OP_STORE): iclass = CL_STORE;
`ifdef CU_BRANCH_EN
      OPCODE_W'(OP_BRZ):   iclass = CL_BRZ;
`endif
      OPCODE_W'(OP_HALT):  iclass = CL_HALT;
      default:             iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer (fetch/decode/execute/mem-wait) owning pc and IR.
// Define CU_BRANCH_EN to enable BRZ (opcode 1101) on zero_flag.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int REG_COUNT  = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int OPCODE_W   = 4,
  localparam int REG_SEL_W = $clog2(REG_COUNT),
  localparam int INSTR_W   = OPCODE_W + 2*REG_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic                 instr_valid,
  input  logic                 mem_ready,
  input  logic                 zero_flag,
  output logic                 instr_req,
  output logic [ADDR_W-1:0]    pc,
  output logic [REG_SEL_W-1:0] reg_a_select,
  output logic [REG_SEL_W-1:0] reg_b_select,
  output logic [REG_COUNT-1:0] write_enable,
  output logic                 reg_clear,
  output logic [3:0]           g_select,
  output logic [1:0]           mb_select,
  output logic                 mf_select,
  output logic                 md_select,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    constant_in,
  output logic                 out_valid,
  output logic                 halted
);

  state_e               state, state_next;
  logic [INSTR_W-1:0]   ir, ir_next;
  logic [ADDR_W-1:0]    pc_next, pc_inc, pc_target;
  logic [REG_SEL_W-1:0] dec_a, dec_b;
  logic [REG_COUNT-1:0] dec_we;
  logic [3:0]           dec_g;
  logic [1:0]           dec_mb;
  logic                 dec_mf, dec_md;
  logic [DATA_W-1:0]    dec_const;
  iclass_e              dec_class;
  logic                 branch_taken;

  cu_decoder #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W),
    .OPCODE_W  (OPCODE_W)
  ) u_decoder (
    .ir          (ir),
    .field_a     (dec_a),
    .field_b     (dec_b),
    .we_onehot   (dec_we),
    .g_select    (dec_g),
    .mb_select   (dec_mb),
    .mf_select   (dec_mf),
    .md_select   (dec_md),
    .constant_in (dec_const),
    .iclass      (dec_class)
  );

  assign pc_inc    = pc + ADDR_W'(1);
  assign pc_target = ADDR_W'({dec_a, dec_b});

`ifdef CU_BRANCH_EN
  assign branch_taken = zero_flag;
`else
  logic unused_zero;
  assign unused_zero  = zero_flag;
  assign branch_taken = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    instr_req    = 1'b0;
    reg_a_select = '0;
    reg_b_select = '0;
    write_enable = '0;
    reg_clear    = 1'b0;
    g_select     = '0;
    mb_select    = '0;
    mf_select    = 1'b0;
    md_select    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    constant_in  = '0;
    out_valid    = 1'b0;
    halted       = 1'b0;

    // IR-derived selects are held quiet in FETCH and HALT so idle outputs read zero
    if (state inside {DECODE, EXECUTE, MEM_WAIT}) begin
      reg_a_select = dec_a;
      reg_b_select = dec_b;
      g_select     = dec_g;
      mb_select    = dec_mb;
      mf_select    = dec_mf;
      md_select    = dec_md;
      constant_in  = dec_const;
    end

    case (state)
      FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          ir_next    = instr_in;
          state_next = DECODE;
        end
      end
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        state_next = FETCH;
        pc_next    = pc_inc;
        case (dec_class)
          CL_ALU:   write_enable = dec_we;
          CL_RST:   reg_clear = 1'b1;
          CL_OUT:   out_valid = 1'b1;
          CL_JMP:   pc_next = pc_target;
          CL_BRZ:   pc_next = branch_taken ? pc_target : pc_inc;
          CL_LOAD, CL_STORE: begin
            state_next = MEM_WAIT;
            pc_next    = pc;
          end
          CL_HALT: begin
            state_next = HALT;
            pc_next    = pc;
          end
          default: ;
        endcase
      end
      MEM_WAIT: begin
        mem_read  = (dec_class == CL_LOAD);
        mem_write = (dec_class == CL_STORE);
        if (mem_ready) begin
          if (dec_class == CL_LOAD) write_enable = dec_we;
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      HALT:    halted = 1'b1;
      default: state_next = FETCH;
    endcase
  end

endmodule
